// File: rtl/dpi_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter and sequencer in front of a single-port memory model.
// One transaction at a time: round-robin grant, optional wait latency, one-cycle strobe, held response.
module dpi_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DELAY = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_we,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_ren,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask
);

    localparam int MW = DATA_W / 8;
    localparam logic [3:0] CNT_INIT = (MEM_DELAY > 0) ? 4'(MEM_DELAY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;   // 1 = LSU, 0 = IFU
    logic                last_q, last_d;     // 1 = LSU was last granted
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]       wmask_q, wmask_d;
    logic [DATA_W-1:0]   resp_q, resp_d;

    logic grant_ifu, grant_lsu, owner_ready;

    always_comb begin
        grant_ifu   = ifu_req_valid && (!lsu_req_valid || last_q);
        grant_lsu   = lsu_req_valid && (!ifu_req_valid || !last_q);
        owner_ready = owner_q ? lsu_resp_ready : ifu_resp_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        resp_d  = resp_q;

        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_resp_data  = '0;
        lsu_resp_data  = '0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        mem_raddr      = '0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        mem_wmask      = '0;

        case (state_q)
            S_IDLE: begin
                // Ready is gated by reset so every output is quiet while reset is held.
                ifu_req_ready = grant_ifu && reset;
                lsu_req_ready = grant_lsu && reset;
                if (grant_ifu || grant_lsu) begin
                    owner_d = grant_lsu;
                    we_d    = grant_lsu ? lsu_req_we    : 1'b0;
                    addr_d  = grant_lsu ? lsu_req_addr  : ifu_req_addr;
                    wdata_d = grant_lsu ? lsu_req_wdata : '0;
                    wmask_d = grant_lsu ? lsu_req_wmask : '0;
                    cnt_d   = CNT_INIT;
                    state_d = (MEM_DELAY > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                mem_ren   = !we_q;
                mem_wen   = we_q;
                mem_raddr = addr_q;
                mem_waddr = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
                resp_d    = we_q ? '0 : mem_rdata;
                state_d   = S_RESP;
            end
            S_RESP: begin
                ifu_resp_valid = !owner_q;
                lsu_resp_valid = owner_q;
                ifu_resp_data  = owner_q ? '0 : resp_q;
                lsu_resp_data  = owner_q ? resp_q : '0;
                if (owner_ready) begin
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            resp_q  <= resp_d;
        end
    end

endmodule

// File: doc/dpi_mem_arbiter.md
Name: dpi_mem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port DPI-C memory model.
- Shares the memory between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Serialises one transaction at a time: round-robin grant, optional programmable wait latency, single-cycle memory strobe, registered response held until the owner accepts it.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- MEM_DELAY, 0, extra wait cycles inserted between grant and memory strobe (0..15), used to model slow memory.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_W  IFU read address.
- ifu_resp_valid  out  1  IFU response data valid.
- ifu_resp_ready  in  1  IFU consumes response.
- ifu_resp_data  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_we  in  1  1=write, 0=read.
- lsu_req_addr  in  ADDR_W  LSU address.
- lsu_req_wdata  in  DATA_W  LSU write data.
- lsu_req_wmask  in  DATA_W/8  LSU byte-enable mask.
- lsu_resp_valid  out  1  LSU response valid (reads and writes).
- lsu_resp_ready  in  1  LSU consumes response.
- lsu_resp_data  out  DATA_W  LSU read data; 0 for writes.
- mem_ren  out  1  memory read strobe.
- mem_raddr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory read data; valid before the posedge that ends the mem_ren cycle.
- mem_wen  out  1  memory write strobe.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory write byte mask.

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP.
- Reset (reset==0, async):
  - state=IDLE, last_grant=LSU, so the IFU wins the first tie.
  - Latched request and response registers cleared.
  - All outputs 0.
  - An in-flight transaction is discarded; no response is ever issued for it.
- IDLE:
  - ifu_req_ready / lsu_req_ready are combinational: high only in IDLE, and only for the granted requester.
  - Single requester valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - On the accepting posedge, latch owner, we (forced 0 for IFU), addr, wdata, wmask.
  - Next state: WAIT with cnt=MEM_DELAY-1 if MEM_DELAY>0, else ACCESS.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==0, go to ACCESS.
  - WAIT occupies exactly MEM_DELAY cycles.
- ACCESS (exactly one cycle):
  - mem_ren=!we, mem_wen=we.
  - mem_raddr/mem_waddr=latched addr; mem_wdata/mem_wmask=latched values.
  - Both strobes are 0 in every other state.
  - Address and data outputs are 0 outside ACCESS.
  - At the closing posedge: resp_data <= mem_rdata for reads, or 0 for writes; go to RESP.
- RESP:
  - The owner's resp_valid=1 and resp_data is held stable.
  - The other requester's resp_valid=0.
  - When owner resp_ready=1: last_grant<=owner, go to IDLE.
  - resp_ready is ignored outside RESP.
- Latency: request accept to resp_valid = MEM_DELAY+2 posedges.
- Minimum occupancy: MEM_DELAY+3 cycles per transaction with an immediately ready consumer.
- Requests arriving outside IDLE see req_ready=0 and must remain valid; no queueing.
- Request inputs changing after acceptance have no effect.
- Back-to-back requests from both masters strictly alternate.
- No address alignment or masking is applied; addr and wmask pass through unchanged.

Test Plan:
- Reset low mid-ACCESS of an LSU write at addr 0x80000010 -> all outputs 0 next sample; no lsu_resp_valid; after release, IFU read of 0x80000000 completes normally.
- IFU read 0x80000000 (mem returns 0x00000413), MEM_DELAY=0 -> ifu_req_ready on cycle 0; mem_ren=1 with raddr 0x80000000 on cycle 1 only; ifu_resp_valid with data 0x00000413 from cycle 2 until ifu_resp_ready.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0b0011 -> one mem_wen pulse with exactly those values; mem_ren=0 throughout; lsu_resp_valid with data 0.
- Both valid continuously from reset for 4 transactions -> grant order IFU, LSU, IFU, LSU; mem strobes never overlap.
- MEM_DELAY=3, LSU read -> mem_ren asserted exactly 4 cycles after accept; resp_valid on cycle 5.
- resp_ready held 0 for 10 cycles while IFU requests -> resp_data stable; ifu_req_ready stays 0; IFU is granted only after the LSU response is consumed.
